// File: rtl/banked_regfile_sync_if.sv
// Bus bundle for banked_regfile_sync: write ports, packed read ports and status.
// The master drives addresses, data and control; the slave returns read data and status.
interface banked_regfile_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                    clear_req;
    logic                    wr_en_a;
    logic [ADDR_W-1:0]       wr_addr_a;
    logic [DATA_W-1:0]       wr_data_a;
    logic                    wr_en_b;
    logic [ADDR_W-1:0]       wr_addr_b;
    logic [DATA_W-1:0]       wr_data_b;
    logic [NRD*ADDR_W-1:0]   rd_addr_a;
    logic [NRD*DATA_W-1:0]   rd_data_a;
    logic [NRD*ADDR_W-1:0]   rd_addr_b;
    logic [NRD*DATA_W-1:0]   rd_data_b;
    logic                    init_busy;
    logic                    wr_drop;

    modport master (
        output clear_req, wr_en_a, wr_addr_a, wr_data_a,
               wr_en_b, wr_addr_b, wr_data_b, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, init_busy, wr_drop
    );

    modport slave (
        input  clear_req, wr_en_a, wr_addr_a, wr_data_a,
               wr_en_b, wr_addr_b, wr_data_b, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, init_busy, wr_drop
    );
endinterface

// File: rtl/banked_regfile_sync.sv
// Two-bank register file: one synchronous write and NRD combinational reads per bank,
// optional write-to-read bypass and a clear sequencer that zeroes both banks.
module banked_regfile_sync #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    banked_regfile_sync_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_clear_idx, w_clear_idx_nxt;
    logic              r_wr_drop, w_wr_drop_nxt;
    logic              w_clr_we, w_commit_a, w_commit_b, w_run;
    logic [DATA_W-1:0] r_mem_a [DEPTH];
    logic [DATA_W-1:0] r_mem_b [DEPTH];

    assign w_run         = (r_state == S_RUN);
    assign bus.init_busy = ~w_run;
    assign bus.wr_drop   = r_wr_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_CLEAR;
            r_clear_idx <= '0;
            r_wr_drop   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_clear_idx <= w_clear_idx_nxt;
            r_wr_drop   <= w_wr_drop_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        w_state_nxt     = r_state;
        w_clear_idx_nxt = r_clear_idx;
        w_wr_drop_nxt   = 1'b0;
        w_clr_we        = 1'b0;
        w_commit_a      = 1'b0;
        w_commit_b      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_wr_drop_nxt = bus.wr_en_a | bus.wr_en_b;
                if (bus.clear_req) begin
                    w_clear_idx_nxt = '0;
                end else if (r_clear_idx == LAST_IDX) begin
                    w_state_nxt     = S_RUN;
                    w_clear_idx_nxt = '0;
                end else begin
                    w_clear_idx_nxt = r_clear_idx + (ADDR_W + 1)'(1);
                end
            end
            S_RUN: begin
                if (bus.clear_req) begin
                    w_state_nxt     = S_CLEAR;
                    w_clear_idx_nxt = '0;
                    w_wr_drop_nxt   = bus.wr_en_a | bus.wr_en_b;
                end else begin
                    // Entry 0 is hard-wired to zero, so writes to it vanish without a drop flag.
                    w_commit_a = bus.wr_en_a && !(ZERO_REG != 0 && bus.wr_addr_a == '0);
                    w_commit_b = bus.wr_en_b && !(ZERO_REG != 0 && bus.wr_addr_b == '0);
                end
            end
        endcase
    end

    // NOTE: the arrays carry no reset; the clear sequencer defines their contents.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem_a[r_clear_idx[ADDR_W-1:0]] <= '0;
            r_mem_b[r_clear_idx[ADDR_W-1:0]] <= '0;
        end else begin
            if (w_commit_a) r_mem_a[bus.wr_addr_a] <= bus.wr_data_a;
            if (w_commit_b) r_mem_b[bus.wr_addr_b] <= bus.wr_data_b;
        end
    end

    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (ZERO_REG != 0 && ra == '0) return '0;
        if (BYPASS != 0 && we && ra == wa) return wd;
        return stored;
    endfunction

    // While clearing, every read port returns zero.
    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        if (w_run) begin
            for (int i = 0; i < NRD; i++) begin
                bus.rd_data_a[i*DATA_W +: DATA_W] = f_read(
                    bus.rd_addr_a[i*ADDR_W +: ADDR_W], r_mem_a[bus.rd_addr_a[i*ADDR_W +: ADDR_W]],
                    bus.wr_en_a, bus.wr_addr_a, bus.wr_data_a);
                bus.rd_data_b[i*DATA_W +: DATA_W] = f_read(
                    bus.rd_addr_b[i*ADDR_W +: ADDR_W], r_mem_b[bus.rd_addr_b[i*ADDR_W +: ADDR_W]],
                    bus.wr_en_b, bus.wr_addr_b, bus.wr_data_b);
            end
        end
    end
endmodule

// File: tb/tb_banked_regfile_sync.sv
// Bench for banked_regfile_sync: a default build (bypass on) and a bypass-off/zero-register
// build share stimulus and are compared against a high-level model of the register file.
module tb_banked_regfile_sync;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_req, wr_en_a, wr_en_b;
    logic [AW-1:0]    wr_addr_a, wr_addr_b;
    logic [DW-1:0]    wr_data_a, wr_data_b;
    logic [NR*AW-1:0] rd_addr_a, rd_addr_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored contents, cycles of clearing left, pending drop flag.
    logic [DW-1:0] m_mem_a [DEPTH];
    logic [DW-1:0] m_mem_b [DEPTH];
    int            m_left;
    logic          m_drop;

    always #5 clk = ~clk;

    banked_regfile_sync_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) if0 ();
    banked_regfile_sync_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) if1 ();

    assign if0.clear_req = clear_req;  assign if1.clear_req = clear_req;
    assign if0.wr_en_a   = wr_en_a;    assign if1.wr_en_a   = wr_en_a;
    assign if0.wr_addr_a = wr_addr_a;  assign if1.wr_addr_a = wr_addr_a;
    assign if0.wr_data_a = wr_data_a;  assign if1.wr_data_a = wr_data_a;
    assign if0.wr_en_b   = wr_en_b;    assign if1.wr_en_b   = wr_en_b;
    assign if0.wr_addr_b = wr_addr_b;  assign if1.wr_addr_b = wr_addr_b;
    assign if0.wr_data_b = wr_data_b;  assign if1.wr_data_b = wr_data_b;
    assign if0.rd_addr_a = rd_addr_a;  assign if1.rd_addr_a = rd_addr_a;
    assign if0.rd_addr_b = rd_addr_b;  assign if1.rd_addr_b = rd_addr_b;

    banked_regfile_sync #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    banked_regfile_sync #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    task automatic model_reset();
        m_left = DEPTH;
        m_drop = 1'b0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_left > 0 || clear_req) begin
            m_drop = wr_en_a | wr_en_b;
            if (clear_req) begin
                m_left = DEPTH;
            end else begin
                m_left--;
                if (m_left == 0)
                    for (int k = 0; k < DEPTH; k++) begin
                        m_mem_a[k] = '0;
                        m_mem_b[k] = '0;
                    end
            end
        end else begin
            m_drop = 1'b0;
            if (wr_en_a) m_mem_a[wr_addr_a] = wr_data_a;
            if (wr_en_b) m_mem_b[wr_addr_b] = wr_data_b;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int inst, input bit bank_b, input logic [AW-1:0] ra);
        bit            byp = (inst == 0);
        bit            zr  = (inst == 1);
        logic          we  = bank_b ? wr_en_b : wr_en_a;
        logic [AW-1:0] wa  = bank_b ? wr_addr_b : wr_addr_a;
        logic [DW-1:0] wd  = bank_b ? wr_data_b : wr_data_a;
        if (m_left > 0) return '0;
        if (zr && ra == '0) return '0;
        if (byp && we && ra == wa) return wd;
        return bank_b ? m_mem_b[ra] : m_mem_a[ra];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk($sformatf("%s:busy0", tag), DW'(if0.init_busy), DW'(m_left > 0));
        chk($sformatf("%s:busy1", tag), DW'(if1.init_busy), DW'(m_left > 0));
        chk($sformatf("%s:drop0", tag), DW'(if0.wr_drop), DW'(m_drop));
        chk($sformatf("%s:drop1", tag), DW'(if1.wr_drop), DW'(m_drop));
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s:d0a%0d", tag, p), if0.rd_data_a[p*DW +: DW], exp_rd(0, 0, rd_addr_a[p*AW +: AW]));
            chk($sformatf("%s:d0b%0d", tag, p), if0.rd_data_b[p*DW +: DW], exp_rd(0, 1, rd_addr_b[p*AW +: AW]));
            chk($sformatf("%s:d1a%0d", tag, p), if1.rd_data_a[p*DW +: DW], exp_rd(1, 0, rd_addr_a[p*AW +: AW]));
            chk($sformatf("%s:d1b%0d", tag, p), if1.rd_data_b[p*DW +: DW], exp_rd(1, 1, rd_addr_b[p*AW +: AW]));
        end
    endtask

    task automatic idle();
        clear_req = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
    endtask

    task automatic rand_rd();
        rd_addr_a = NR*AW'($urandom);
        rd_addr_b = NR*AW'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Clear after reset: busy for exactly DEPTH edges.
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            rand_rd();
            check_all($sformatf("clr%0d", k));
            if (k == DEPTH - 2) chk("busy_before_end", DW'(if0.init_busy), 1);
        end
        chk("busy_len", DW'(if0.init_busy), 0);

        for (int k = 0; k < DEPTH; k += 2) begin
            rd_addr_a = {AW'(k + 1), AW'(k)};
            rd_addr_b = {AW'(k), AW'(k + 1)};
            check_all($sformatf("zero%0d", k));
        end

        // Basic write on both banks to the same address.
        wr_en_a = 1'b1; wr_addr_a = 5; wr_data_a = 32'hDEADBEEF;
        wr_en_b = 1'b1; wr_addr_b = 5; wr_data_b = 32'h12345678;
        tick();
        idle();
        rd_addr_a = {AW'(5), AW'(5)};
        rd_addr_b = {AW'(5), AW'(9)};
        check_all("basic");
        chk("basic_a0", if0.rd_data_a[0 +: DW], 32'hDEADBEEF);
        chk("basic_a1", if0.rd_data_a[DW +: DW], 32'hDEADBEEF);
        chk("basic_b1", if0.rd_data_b[DW +: DW], 32'h12345678);

        // Bypass: A[7]=1, then write 2 while reading 7.
        wr_en_a = 1'b1; wr_addr_a = 7; wr_data_a = 32'h1;
        tick();
        wr_data_a = 32'h2;
        rd_addr_a = {AW'(7), AW'(7)};
        check_all("byp_same");
        chk("byp_on", if0.rd_data_a[0 +: DW], 32'h2);
        chk("byp_off", if1.rd_data_a[0 +: DW], 32'h1);
        tick();
        idle();
        check_all("byp_next");
        chk("byp_off_next", if1.rd_data_a[0 +: DW], 32'h2);

        // Entry 0 writes on both banks.
        wr_en_a = 1'b1; wr_addr_a = 0; wr_data_a = '1;
        wr_en_b = 1'b1; wr_addr_b = 0; wr_data_b = '1;
        rd_addr_a = '0; rd_addr_b = '0;
        check_all("zr_same");
        chk("zr_byp", if1.rd_data_a[0 +: DW], 0);
        tick();
        idle();
        check_all("zr_next");
        chk("zr_a0", if1.rd_data_a[0 +: DW], 0);
        chk("zr_b0", if1.rd_data_b[0 +: DW], 0);
        chk("zr_drop", DW'(if1.wr_drop), 0);

        // Write in the same cycle as a clear request is discarded.
        wr_en_a = 1'b1; wr_addr_a = 3; wr_data_a = 32'h55;
        tick();
        clear_req = 1'b1; wr_data_a = 32'hAA;
        rd_addr_a = {AW'(3), AW'(3)};
        check_all("clrw_req");
        tick();
        idle();
        check_all("clrw_drop");
        chk("clrw_drop_hi", DW'(if0.wr_drop), 1);
        tick();
        check_all("clrw_drop_lo");
        for (int k = 2; k < DEPTH; k++) tick();
        check_all("clrw_done");
        chk("clrw_a3", if0.rd_data_a[0 +: DW], 0);

        // Randomised traffic with occasional clears.
        for (int k = 0; k < 400; k++) begin
            tick();
            clear_req = ($urandom_range(0, 63) == 0);
            wr_en_a   = 1'($urandom); wr_addr_a = AW'($urandom); wr_data_a = $urandom;
            wr_en_b   = 1'($urandom); wr_addr_b = AW'($urandom); wr_data_b = $urandom;
            rand_rd();
            if ($urandom_range(0, 3) == 0) rd_addr_a[0 +: AW] = wr_addr_a;
            if ($urandom_range(0, 3) == 0) rd_addr_b[AW +: AW] = wr_addr_b;
            check_all($sformatf("rnd%0d", k));
        end

        // Reset ten cycles into a clear restarts the full sequence.
        idle();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        model_reset();
        check_all("midrst");
        chk("midrst_busy", DW'(if0.init_busy), 1);
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            rand_rd();
            check_all($sformatf("rclr%0d", k));
            if (k == DEPTH - 2) chk("rclr_busy_end", DW'(if1.init_busy), 1);
        end
        chk("rclr_len", DW'(if1.init_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
